lpc_packer: RTL and testbench

Downstream stage of the LPC decoder: captures each completed LPC cycle (cycle type/direction, address, data) on the rising edge of the decoder's completion strobe. It optionally filters cycles to a single I/O-write port (POST code). It buffers accepted cycles in a small record FIFO and serializes each one as a fixed 6-byte frame over a valid/ready byte stream for the UART transmitter. Runs entirely in the LPC clock domain.

---
 rtl/lpc_pkg.sv | 37 +++
 rtl/lpc_record_fifo.sv | 72 +++++++
 rtl/lpc_packer.sv | 99 +++++++++
 tb/tb_lpc_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants and types for the LPC cycle packer.
//   - cycle-type encoding fields used by the capture filter
//   - output frame geometry (6 bytes, marker nibble in byte 0)
//   - packed record type and the frame byte selector
package lpc_pkg;

    localparam logic [1:0] CYC_IO       = 2'b00;
    localparam logic [1:0] CYC_MEM      = 2'b01;
    localparam int         DIR_WRITE    = 1;

    localparam int         FRAME_BYTES  = 6;
    localparam logic [3:0] FRAME_MARKER = 4'h5;
    localparam int         REC_W        = 44;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [31:0] addr;
        logic [7:0]  data;
    } lpc_rec_t;

    typedef logic [2:0] byte_idx_t;

    // Byte 0 carries the marker so a receiver can resynchronise on frame starts.
    function automatic logic [7:0] frame_byte(input lpc_rec_t rec, input byte_idx_t idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {FRAME_MARKER, rec.cyctype_dir};
            3'd1:    b = rec.addr[31:24];
            3'd2:    b = rec.addr[23:16];
            3'd3:    b = rec.addr[15:8];
            3'd4:    b = rec.addr[7:0];
            default: b = rec.data;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lpc_record_fifo.sv
// lpc_record_fifo: first-word-fall-through record FIFO.
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, wr_data_i write request and record; ignored when full unless popping
//   pop_i             remove head record; ignored when empty
//   rd_data_o         head record (valid while ~empty_o)
//   full_o, empty_o   occupancy flags; count_o holds 0..DEPTH
module lpc_record_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates its visibility, so stale words never escape.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/lpc_packer.sv
// lpc_packer: captures completed LPC cycles, optionally filters to one I/O-write
// port, queues them and serialises each as a 6-byte frame on a valid/ready stream.
//   lpc_clock, reset            clock, asynchronous active-high reset
//   in_cyctype_dir/addr/data    decoder cycle fields, sampled on capture
//   in_clock_enable             decoder completion level; rising edge = new cycle
//   out_data/out_valid/out_ready byte stream to the UART transmitter
//   overflow, drop_count        sticky drop flag and saturating drop counter
module lpc_packer
    import lpc_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter bit          FILTER_EN   = 1'b0,
    parameter logic [15:0] FILTER_ADDR = 16'h0080
) (
    input  logic        lpc_clock,
    input  logic        reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        in_clock_enable,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

    logic                  ce_q;
    byte_idx_t             idx_q, idx_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  capture, is_io_wr, accept;
    logic                  handshake, pop, drop;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    lpc_rec_t              wr_rec, head_rec;

    assign capture  = in_clock_enable & ~ce_q;
    assign is_io_wr = (in_cyctype_dir[3:2] == CYC_IO) & in_cyctype_dir[DIR_WRITE];
    assign accept   = capture & (!FILTER_EN | (is_io_wr & (in_addr[15:0] == FILTER_ADDR)));

    assign wr_rec   = '{cyctype_dir: in_cyctype_dir, addr: in_addr, data: in_data};

    assign handshake = out_valid & out_ready;
    assign pop       = handshake & (idx_q == LAST_IDX);
    // A capture into a full FIFO survives only if the head frame completes this cycle.
    assign drop      = accept & fifo_full & ~pop;

    lpc_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (lpc_clock),
        .rst_i     (reset),
        .push_i    (accept),
        .wr_data_i (wr_rec),
        .pop_i     (pop),
        .rd_data_o (head_rec),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // The record stays queued until byte 5 is taken, so valid cannot drop mid-frame.
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : frame_byte(head_rec, idx_q);

    always_comb begin
        idx_d      = idx_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (handshake) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge lpc_clock or posedge reset) begin
        if (reset) begin
            ce_q       <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            ce_q       <= in_clock_enable;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_lpc_packer.sv
// Scoreboard bench: two DUT copies share the stimulus, one unfiltered and one
// filtering to I/O writes of port 0x80. Expected frame bytes are queued when a
// cycle is issued; per-instance monitors pop and compare on every handshake.
module tb_lpc_packer;

    logic        lpc_clock = 1'b0;
    logic        reset;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        in_clock_enable;
    logic        out_ready;

    logic [7:0]  out_data_m, out_data_f;
    logic        out_valid_m, out_valid_f;
    logic        ov_m, ov_f;
    logic [7:0]  dc_m, dc_f;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_m     = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_f[$];

    always #5 lpc_clock = ~lpc_clock;

    lpc_packer #(.DEPTH(8), .FILTER_EN(1'b0), .FILTER_ADDR(16'h0080)) dut_m (
        .lpc_clock(lpc_clock), .reset(reset), .in_cyctype_dir(in_cyctype_dir),
        .in_addr(in_addr), .in_data(in_data), .in_clock_enable(in_clock_enable),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .overflow(ov_m), .drop_count(dc_m)
    );

    lpc_packer #(.DEPTH(8), .FILTER_EN(1'b1), .FILTER_ADDR(16'h0080)) dut_f (
        .lpc_clock(lpc_clock), .reset(reset), .in_cyctype_dir(in_cyctype_dir),
        .in_addr(in_addr), .in_data(in_data), .in_clock_enable(in_clock_enable),
        .out_data(out_data_f), .out_valid(out_valid_f), .out_ready(out_ready),
        .overflow(ov_f), .drop_count(dc_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic push_frame(input bit filt, input logic [3:0] c, input logic [31:0] a,
                              input logic [7:0] d);
        logic [7:0] b[6];
        b[0] = {4'h5, c}; b[1] = a[31:24]; b[2] = a[23:16];
        b[3] = a[15:8];   b[4] = a[7:0];   b[5] = d;
        for (int i = 0; i < 6; i++) begin
            if (filt) exp_f.push_back(b[i]);
            else      exp_m.push_back(b[i]);
        end
    endtask

    // Raise the completion level for one edge, then drop it for one edge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d,
                         input bit acc_m, input bit acc_f);
        in_cyctype_dir  = c;
        in_addr         = a;
        in_data         = d;
        in_clock_enable = 1'b1;
        if (acc_m) push_frame(1'b0, c, a, d);
        if (acc_f) push_frame(1'b1, c, a, d);
        tick();
        in_clock_enable = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_m.size() != 0 || exp_f.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_drain_m"}, exp_m.size(), 0);
        check({name, "_drain_f"}, exp_f.size(), 0);
    endtask

    // Monitor for the unfiltered copy, including hold-while-stalled checking.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge lpc_clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_m", {out_valid_m, out_data_m}, {1'b1, prev_data});
            if (out_valid_m && out_ready) begin
                hs_m++;
                if (exp_m.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte_m: got %h expected none", out_data_m);
                end else begin
                    check("byte_m", out_data_m, exp_m.pop_front());
                end
            end
            prev_stall = out_valid_m & ~out_ready;
            prev_data  = out_data_m;
        end
    end

    always @(negedge lpc_clock) begin
        if (!reset && out_valid_f && out_ready) begin
            if (exp_f.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte_f: got %h expected none", out_data_f);
            end else begin
                check("byte_f", out_data_f, exp_f.pop_front());
            end
        end
    end

    initial begin
        int hs_start;
        reset           = 1'b1;
        in_cyctype_dir  = 4'h0;
        in_addr         = 32'h0;
        in_data         = 8'h0;
        in_clock_enable = 1'b0;
        out_ready       = 1'b0;
        #1;
        check("rst_valid_m", out_valid_m, 1'b0);
        check("rst_data_m",  out_data_m,  8'h00);
        check("rst_ovf_m",   ov_m,        1'b0);
        check("rst_drop_m",  dc_m,        8'h00);
        check("rst_valid_f", out_valid_f, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single I/O write: byte 0 visible in the cycle after the capture edge.
        out_ready       = 1'b1;
        in_cyctype_dir  = 4'b0010;
        in_addr         = 32'h0000_0080;
        in_data         = 8'hA5;
        in_clock_enable = 1'b1;
        push_frame(1'b0, 4'b0010, 32'h0000_0080, 8'hA5);
        push_frame(1'b1, 4'b0010, 32'h0000_0080, 8'hA5);
        tick();
        check("first_valid", out_valid_m, 1'b1);
        check("first_byte",  out_data_m,  8'h52);
        in_clock_enable = 1'b0;
        drain("single");

        // Memory read under alternating backpressure.
        out_ready = 1'b0;
        issue(4'b0100, 32'hFFFF_FFF0, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        drain("bp");

        // Filter: only the I/O write to 0x80 reaches the filtered copy.
        issue(4'b0010, 32'h0000_0080, 8'h77, 1'b1, 1'b1);
        issue(4'b0010, 32'h0000_0081, 8'h78, 1'b1, 1'b0);
        issue(4'b0000, 32'h0000_0080, 8'h79, 1'b1, 1'b0);
        drain("filter");
        check("filter_drop_f", dc_f, 8'h00);
        check("filter_drop_m", dc_m, 8'h00);
        check("filter_ovf_f",  ov_f, 1'b0);

        // Overflow: ten captures into depth 8 with the output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            issue(4'b0110, 32'h1000_0000 + i, 8'(i + 8'hC0), i < 8, 1'b0);
        check("ovf_flag",  ov_m, 1'b1);
        check("ovf_count", dc_m, 8'd2);
        check("ovf_fill",  dut_m.u_fifo.count_o, 8);
        check("ovf_flag_f", ov_f, 1'b0);
        hs_start  = hs_m;
        out_ready = 1'b1;
        drain("ovf");
        repeat (4) tick();
        check("ovf_bytes", hs_m - hs_start, 48);

        // Full FIFO: capture coincides with the byte-5 handshake of the head frame.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            issue(4'b0110, 32'h2000_0000 + i, 8'(i), 1'b1, 1'b0);
        check("fp_fill", dut_m.u_fifo.count_o, 8);
        out_ready = 1'b1;
        repeat (5) tick();
        in_cyctype_dir  = 4'b0110;
        in_addr         = 32'h2000_00AA;
        in_data         = 8'hEE;
        in_clock_enable = 1'b1;
        push_frame(1'b0, 4'b0110, 32'h2000_00AA, 8'hEE);
        tick();
        in_clock_enable = 1'b0;
        check("fp_count", dut_m.u_fifo.count_o, 8);
        check("fp_drop",  dc_m, 8'd2);
        drain("fp");

        // Reset mid-frame: discard everything, stay quiet after release.
        out_ready = 1'b0;
        issue(4'b0010, 32'h0000_0080, 8'h11, 1'b1, 1'b1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        exp_m.delete();
        exp_f.delete();
        #1;
        check("midrst_valid_m", out_valid_m, 1'b0);
        check("midrst_data_m",  out_data_m,  8'h00);
        check("midrst_valid_f", out_valid_f, 1'b0);
        check("midrst_drop_m",  dc_m,        8'h00);
        repeat (2) tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("postrst_valid_m", out_valid_m, 1'b0);
        check("postrst_data_m",  out_data_m,  8'h00);
        check("postrst_valid_f", out_valid_f, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
